pwm_demod: RTL and testbench



---
 rtl/music_pkg.sv | 17 +
 rtl/pwm_demod_if.sv | 24 ++
 rtl/pwm_in_sync.sv | 35 +++
 rtl/pwm_demod.sv | 159 +++++++++++++++
 tb/tb_pwm_demod.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/music_pkg.sv
// Shared definitions for the music path: demodulator state encoding, the default
// PWM frame width shared with the generator, and the saturation-limit helper.
package music_pkg;

    localparam int FRAME_W_DEFAULT = 8;

    typedef enum logic {
        HUNT  = 1'b0,
        TRACK = 1'b1
    } demod_state_e;

    // Largest value representable in w bits, i.e. the last phase of a 2^w frame.
    function automatic int unsigned sat_limit(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/pwm_demod_if.sv
// Valid/ready sample channel between the PWM demodulator and its consumer.
interface pwm_demod_if
    import music_pkg::*;
#(
    parameter int SAMPLE_W = FRAME_W_DEFAULT
);

    logic [SAMPLE_W-1:0] sample;
    logic                sample_valid;
    logic                sample_ready;

    modport master (
        output sample,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample,
        input  sample_valid,
        output sample_ready
    );

endinterface

// File: rtl/pwm_in_sync.sv
// Brings the asynchronous PWM line into the clk domain and flags its rising edges.
module pwm_in_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pwm_in,
    output logic pwm_s,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   pwm_d_q;
    logic                   pwm_d_d;

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], pwm_in};
        pwm_d_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            pwm_d_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            pwm_d_q <= pwm_d_d;
        end
    end

    assign pwm_s = sync_q[SYNC_STAGES-1];
    assign rise  = pwm_s & ~pwm_d_q;

endmodule

// File: rtl/pwm_demod.sv
// Recovers one duty-cycle sample per PWM frame, tracking frame phase from the
// line's rising edges and handing samples out through a one-entry valid/ready buffer.
module pwm_demod
    import music_pkg::*;
#(
    parameter int SAMPLE_W    = FRAME_W_DEFAULT,
    parameter int SYNC_STAGES = 2,
    parameter int RELOCK_ERRS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pwm_in,
    pwm_demod_if.master out_if,
    output logic       locked,
    output logic       overrun
);

    localparam int ACC_W = SAMPLE_W + 1;
    localparam logic [SAMPLE_W-1:0] PHASE_LAST = SAMPLE_W'(sat_limit(SAMPLE_W));
    localparam logic [ACC_W-1:0]    ACC_LIMIT  = ACC_W'(sat_limit(SAMPLE_W));
    localparam logic [3:0]          ERR_LIMIT  = 4'(RELOCK_ERRS);

    logic pwm_s;
    logic rise;

    demod_state_e        state_q,   state_d;
    logic [SAMPLE_W-1:0] phase_q,   phase_d;
    logic [ACC_W-1:0]    acc_q,     acc_d;
    logic [3:0]          err_q,     err_d;
    logic                good_q,    good_d;
    logic                bad_q,     bad_d;
    logic [SAMPLE_W-1:0] sample_q,  sample_d;
    logic                valid_q,   valid_d;
    logic                overrun_q, overrun_d;

    logic [ACC_W-1:0]    sum;
    logic [SAMPLE_W-1:0] result;
    logic [3:0]          err_inc;
    logic                publish;

    pwm_in_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .pwm_in(pwm_in),
        .pwm_s (pwm_s),
        .rise  (rise)
    );

    // good/bad remember whether this frame saw a rise on phase 0 or anywhere else.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        acc_d   = acc_q;
        err_d   = err_q;
        good_d  = good_q;
        bad_d   = bad_q;
        publish = 1'b0;
        sum     = acc_q + {{SAMPLE_W{1'b0}}, pwm_s};
        result  = (sum > ACC_LIMIT) ? ACC_LIMIT[SAMPLE_W-1:0] : sum[SAMPLE_W-1:0];
        err_inc = err_q + 4'd1;

        case (state_q)
            HUNT: begin
                phase_d = '0;
                acc_d   = '0;
                err_d   = '0;
                good_d  = 1'b0;
                bad_d   = 1'b0;
                if (rise) begin
                    state_d = TRACK;
                    phase_d = SAMPLE_W'(1);
                    acc_d   = ACC_W'(1);
                    good_d  = 1'b1;
                end
            end
            TRACK: begin
                phase_d = phase_q + SAMPLE_W'(1);
                if (phase_q == '0) begin
                    acc_d  = {{SAMPLE_W{1'b0}}, pwm_s};
                    good_d = rise;
                    bad_d  = 1'b0;
                end else begin
                    acc_d = sum;
                    if (rise) begin
                        bad_d = 1'b1;
                    end
                end

                // Frame end: settle the alignment verdict and publish unless lock is lost.
                if (phase_q == PHASE_LAST) begin
                    if (bad_q || rise) begin
                        if (err_inc >= ERR_LIMIT) begin
                            state_d = HUNT;
                            err_d   = '0;
                            phase_d = '0;
                            acc_d   = '0;
                        end else begin
                            err_d   = err_inc;
                            publish = 1'b1;
                        end
                    end else begin
                        if (good_q) begin
                            err_d = '0;
                        end
                        publish = 1'b1;
                    end
                end
            end
        endcase
    end

    // A publish always wins the buffer; overrun marks a sample lost while stalled.
    always_comb begin
        sample_d  = sample_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (publish) begin
            sample_d = result;
            valid_d  = 1'b1;
            if (valid_q && !out_if.sample_ready) begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && out_if.sample_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= HUNT;
            phase_q   <= '0;
            acc_q     <= '0;
            err_q     <= '0;
            good_q    <= 1'b0;
            bad_q     <= 1'b0;
            sample_q  <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            acc_q     <= acc_d;
            err_q     <= err_d;
            good_q    <= good_d;
            bad_q     <= bad_d;
            sample_q  <= sample_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign out_if.sample       = sample_q;
    assign out_if.sample_valid = valid_q;
    assign locked              = (state_q == TRACK);
    assign overrun             = overrun_q;

endmodule

// File: tb/tb_pwm_demod.sv
// Drives pwm_demod with built PWM waveforms and compares every cycle against a
// frame-level reference model derived from the demodulator's behavioural rules.
module tb_pwm_demod;

    import music_pkg::*;

    localparam int W      = 8;
    localparam int SYNC   = 2;
    localparam int RELOCK = 4;
    localparam int FRAME  = 256;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pwm_in = 1'b0;
    logic locked;
    logic overrun;

    pwm_demod_if #(.SAMPLE_W(W)) dut_if ();

    pwm_demod #(
        .SAMPLE_W   (W),
        .SYNC_STAGES(SYNC),
        .RELOCK_ERRS(RELOCK)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .pwm_in (pwm_in),
        .out_if (dut_if),
        .locked (locked),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    int cur_cycle  = 0;

    bit pin_q[$];
    bit rdy_q[$];
    bit s_arr[];
    bit exp_lock[];
    bit exp_pub[];
    int exp_val[];

    typedef struct {
        int duty;
        int frames;
        bit rdy;
        int exp_sample;
        bit exp_valid;
        bit exp_locked;
        bit exp_overrun;
    } vec_t;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s cycle %0d: got %0d want %0d", name, cur_cycle, actual, expected);
        end
    endtask

    task automatic clearWave();
        pin_q.delete();
        rdy_q.delete();
    endtask

    task automatic addFrame(input int duty, input bit rdy);
        for (int i = 0; i < FRAME; i++) begin
            pin_q.push_back(i < duty);
            rdy_q.push_back(rdy);
        end
    endtask

    task automatic addConst(input bit v, input int n, input bit rdy);
        for (int i = 0; i < n; i++) begin
            pin_q.push_back(v);
            rdy_q.push_back(rdy);
        end
    endtask

    function automatic bit isRise(input int t);
        if (t == 0) return s_arr[0];
        return s_arr[t] && !s_arr[t-1];
    endfunction

    // Whole-frame view: find a lock edge, then judge each 256-cycle window as a unit.
    task automatic runModel();
        int n, t, f, e, sum, err;
        bit good, bad, tracking;
        n = pin_q.size();
        s_arr    = new[n];
        exp_lock = new[n+1];
        exp_pub  = new[n];
        exp_val  = new[n];
        for (int i = 0; i < n; i++) begin
            s_arr[i]   = (i >= SYNC) ? pin_q[i-SYNC] : 1'b0;
            exp_pub[i] = 1'b0;
            exp_val[i] = 0;
        end
        for (int i = 0; i <= n; i++) exp_lock[i] = 1'b0;
        t = 0;
        while (t < n) begin
            if (!isRise(t)) begin
                t++;
            end else begin
                f = t;
                err = 0;
                tracking = 1'b1;
                while (tracking) begin
                    e = f + FRAME - 1;
                    for (int i = f + 1; i <= e && i <= n; i++) exp_lock[i] = 1'b1;
                    if (e >= n) begin
                        tracking = 1'b0;
                        t = n;
                    end else begin
                        sum = 0;
                        bad = 1'b0;
                        for (int i = f; i <= e; i++) sum += s_arr[i];
                        for (int i = f + 1; i <= e; i++) if (isRise(i)) bad = 1'b1;
                        good = isRise(f);
                        if (bad) err++;
                        else if (good) err = 0;
                        if (err == RELOCK) begin
                            tracking = 1'b0;
                            t = e + 1;
                        end else begin
                            exp_pub[e] = 1'b1;
                            exp_val[e] = (sum > FRAME - 1) ? FRAME - 1 : sum;
                            exp_lock[e+1] = 1'b1;
                            f = e + 1;
                        end
                    end
                end
            end
        end
    endtask

    task automatic checkCycle(input int c, input bit mv, input int ms, input bit mo);
        cur_cycle = c;
        checkOutput("locked", 32'(locked), 32'(exp_lock[c]));
        checkOutput("sample_valid", 32'(dut_if.sample_valid), 32'(mv));
        checkOutput("sample", 32'(dut_if.sample), 32'(ms));
        checkOutput("overrun", 32'(overrun), 32'(mo));
    endtask

    // Reset, then play the waveform while the one-entry buffer is modelled alongside.
    task automatic applyStimulus(input int limit);
        int n, ms;
        bit mv, mo;
        n = (limit < pin_q.size()) ? limit : pin_q.size();
        rst_n = 1'b0;
        pwm_in = 1'b0;
        dut_if.sample_ready = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mv = 1'b0;
        mo = 1'b0;
        ms = 0;
        for (int c = 0; c < n; c++) begin
            checkCycle(c, mv, ms, mo);
            pwm_in = pin_q[c];
            dut_if.sample_ready = rdy_q[c];
            if (exp_pub[c]) begin
                if (mv && !rdy_q[c]) mo = 1'b1;
                ms = exp_val[c];
                mv = 1'b1;
            end else if (mv && rdy_q[c]) begin
                mv = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        checkCycle(n, mv, ms, mo);
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{duty: 100, frames: 3, rdy: 1'b1, exp_sample: 100, exp_valid: 1'b0, exp_locked: 1'b1, exp_overrun: 1'b0};
        vecs[1] = '{duty: 1,   frames: 2, rdy: 1'b1, exp_sample: 1,   exp_valid: 1'b0, exp_locked: 1'b1, exp_overrun: 1'b0};
        vecs[2] = '{duty: 255, frames: 2, rdy: 1'b1, exp_sample: 255, exp_valid: 1'b0, exp_locked: 1'b1, exp_overrun: 1'b0};
        vecs[3] = '{duty: 128, frames: 2, rdy: 1'b0, exp_sample: 128, exp_valid: 1'b1, exp_locked: 1'b1, exp_overrun: 1'b1};
        vecs[4] = '{duty: 0,   frames: 2, rdy: 1'b1, exp_sample: 0,   exp_valid: 1'b0, exp_locked: 1'b0, exp_overrun: 1'b0};
        vecs[5] = '{duty: 200, frames: 1, rdy: 1'b0, exp_sample: 200, exp_valid: 1'b1, exp_locked: 1'b1, exp_overrun: 1'b0};

        // Idle line: never locks, never produces anything.
        clearWave();
        addConst(1'b0, 2000, 1'b1);
        runModel();
        applyStimulus(1 << 30);
        checkOutput("idle_locked", 32'(locked), 32'd0);
        checkOutput("idle_valid", 32'(dut_if.sample_valid), 32'd0);

        for (int v = 0; v < 6; v++) begin
            clearWave();
            for (int k = 0; k < vecs[v].frames; k++) addFrame(vecs[v].duty, vecs[v].rdy);
            addConst(1'b0, 4, vecs[v].rdy);
            runModel();
            applyStimulus(1 << 30);
            checkOutput("vec_sample", 32'(dut_if.sample), 32'(vecs[v].exp_sample));
            checkOutput("vec_valid", 32'(dut_if.sample_valid), 32'(vecs[v].exp_valid));
            checkOutput("vec_locked", 32'(locked), 32'(vecs[v].exp_locked));
            checkOutput("vec_overrun", 32'(overrun), 32'(vecs[v].exp_overrun));
        end

        // Empty frame, near-full frame, then the line stuck high for two frames.
        clearWave();
        addFrame(64, 1'b1);
        addFrame(0, 1'b1);
        addFrame(255, 1'b1);
        addConst(1'b1, 2 * FRAME, 1'b1);
        addConst(1'b0, 8, 1'b1);
        runModel();
        applyStimulus(1 << 30);
        checkOutput("stuck_sample", 32'(dut_if.sample), 32'd255);
        checkOutput("stuck_locked", 32'(locked), 32'd1);

        // Consumer stalled for three frames, then drains.
        clearWave();
        addFrame(10, 1'b0);
        addFrame(20, 1'b0);
        addFrame(30, 1'b0);
        addConst(1'b0, 7, 1'b0);
        addConst(1'b0, 5, 1'b1);
        runModel();
        applyStimulus(1 << 30);
        checkOutput("stall_sample", 32'(dut_if.sample), 32'd30);
        checkOutput("stall_overrun", 32'(overrun), 32'd1);
        checkOutput("stall_valid", 32'(dut_if.sample_valid), 32'd0);

        // Phase slip of 17 clocks: lock drops after four bad frames, then relocks.
        clearWave();
        for (int k = 0; k < 3; k++) addFrame(64, 1'b1);
        addConst(1'b0, 17, 1'b1);
        for (int k = 0; k < 7; k++) addFrame(64, 1'b1);
        addConst(1'b0, 8, 1'b1);
        runModel();
        applyStimulus(1 << 30);
        checkOutput("slip_sample", 32'(dut_if.sample), 32'd64);
        checkOutput("slip_locked", 32'(locked), 32'd1);

        // Reset dropped between clock edges while a sample is pending.
        clearWave();
        for (int k = 0; k < 3; k++) addFrame(50, 1'b0);
        runModel();
        applyStimulus(600);
        #1;
        rst_n = 1'b0;
        #1;
        cur_cycle = -1;
        checkOutput("rst_sample", 32'(dut_if.sample), 32'd0);
        checkOutput("rst_valid", 32'(dut_if.sample_valid), 32'd0);
        checkOutput("rst_locked", 32'(locked), 32'd0);
        checkOutput("rst_overrun", 32'(overrun), 32'd0);
        clearWave();
        for (int k = 0; k < 3; k++) addFrame(77, 1'b1);
        addConst(1'b0, 4, 1'b1);
        runModel();
        applyStimulus(1 << 30);
        checkOutput("post_rst_sample", 32'(dut_if.sample), 32'd77);

        // Random duties, random slips and a randomly stalling consumer.
        for (int r = 0; r < 3; r++) begin
            clearWave();
            for (int k = 0; k < 10; k++) begin
                if ($urandom_range(0, 5) == 0) addConst(1'b0, int'($urandom_range(1, 40)), 1'b1);
                addFrame(int'($urandom_range(0, 255)), 1'b1);
            end
            addConst(1'b0, 8, 1'b1);
            for (int i = 0; i < rdy_q.size(); i++) rdy_q[i] = ($urandom_range(0, 3) != 0);
            runModel();
            applyStimulus(1 << 30);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
